// File: rtl/vending_machine_top.sv
// Board-level vending-machine controller: buttons add coins, buy or refund.
// Credit is held in pence. LEDs show the dispensed item and the credit in 25p units.
module vending_machine_top #(
  parameter logic [9:0] COIN_P     = 10'd100,
  parameter logic [9:0] PRICE0_P   = 10'd50,
  parameter logic [9:0] PRICE1_P   = 10'd80,
  parameter logic [9:0] PRICE2_P   = 10'd60,
  parameter logic [9:0] PRICE3_P   = 10'd120,
  parameter logic [9:0] PRICE4_P   = 10'd200,
  parameter logic [9:0] CREDIT_MAX = 10'd775
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_REFUND,
    ACT_BUY,
    ACT_INSERT
  } action_t;

  logic       clk;
  logic       rst_n;
  logic [3:1] key_prev;
  logic [3:1] press;
  logic [9:0] credit;
  logic [9:0] credit_next;
  logic [4:0] disp;
  logic [4:0] disp_next;
  logic [4:0] credit_led;
  logic [4:0] credit_led_next;
  logic [9:0] sel_price;
  logic       sel_valid;
  logic [10:0] credit_sum;
  action_t    action;
  logic       unused_sw;

  assign clk       = CLOCK_50;
  assign rst_n     = KEY[0];
  assign unused_sw = ^SW[9:5];

  // A button is pressed on the first clock it is seen low; holding it does nothing more.
  assign press = ~KEY[3:1] & key_prev;

  always_comb begin
    if (press[2])      action = ACT_REFUND;
    else if (press[1]) action = ACT_BUY;
    else if (press[3]) action = ACT_INSERT;
    else               action = ACT_NONE;
  end

  always_comb begin
    sel_valid = 1'b1;
    sel_price = '0;
    case (SW[4:0])
      5'b00001: sel_price = PRICE0_P;
      5'b00010: sel_price = PRICE1_P;
      5'b00100: sel_price = PRICE2_P;
      5'b01000: sel_price = PRICE3_P;
      5'b10000: sel_price = PRICE4_P;
      default:  sel_valid = 1'b0;
    endcase
  end

  // One bit wider so the ceiling test cannot wrap.
  assign credit_sum = {1'b0, credit} + {1'b0, COIN_P};

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    credit_next = credit;
    disp_next   = disp;
    unique case (action)
      ACT_REFUND: begin
        credit_next = '0;
        disp_next   = '0;
      end
      ACT_BUY: begin
        if (sel_valid && (credit >= sel_price)) begin
          credit_next = credit - sel_price;
          disp_next   = SW[4:0];
        end else begin
          disp_next   = '0;
        end
      end
      ACT_INSERT: begin
        if (credit_sum <= {1'b0, CREDIT_MAX}) credit_next = credit_sum[9:0];
      end
      default: ;
    endcase
    // The credit ceiling keeps the quotient within five bits.
    credit_led_next = 5'(credit_next / 10'd25);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev   <= 3'b111;
      credit     <= '0;
      disp       <= '0;
      credit_led <= '0;
    end else begin
      key_prev   <= KEY[3:1];
      credit     <= credit_next;
      disp       <= disp_next;
      credit_led <= credit_led_next;
    end
  end

  assign LEDR = {credit_led, disp};

endmodule

// File: tb/tb_vending_machine_top.sv
// Self-checking bench for vending_machine_top: pence-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vending_machine_top;

  logic       CLOCK_50;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state: credit in pence, item shown, last button levels.
  int         exp_credit;
  logic [4:0] exp_disp;
  logic [3:1] exp_prev;

  localparam int PRICES [5] = '{50, 80, 60, 120, 200};

  vending_machine_top dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .LEDR     (LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Price of a selection, or -1 when the selection is not exactly one item.
  function automatic int price_of(input logic [4:0] sel);
    int p;
    p = -1;
    if ($countones(sel) == 1)
      for (int i = 0; i < 5; i++)
        if (sel[i]) p = PRICES[i];
    return p;
  endfunction

  always @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      exp_credit <= 0;
      exp_disp   <= 5'b0;
      exp_prev   <= 3'b111;
    end else begin
      exp_prev <= KEY[3:1];
      if (!KEY[2] && exp_prev[2]) begin
        exp_credit <= 0;
        exp_disp   <= 5'b0;
      end else if (!KEY[1] && exp_prev[1]) begin
        if (price_of(SW[4:0]) >= 0 && exp_credit >= price_of(SW[4:0])) begin
          exp_credit <= exp_credit - price_of(SW[4:0]);
          exp_disp   <= SW[4:0];
        end else begin
          exp_disp   <= 5'b0;
        end
      end else if (!KEY[3] && exp_prev[3]) begin
        if (exp_credit + 100 <= 775) exp_credit <= exp_credit + 100;
      end
    end
  end

  // Every cycle, mid-period, the LEDs must match the model.
  always @(negedge CLOCK_50) begin
    if (chk_en) check("model_ledr", 32'(LEDR), 32'({5'(exp_credit / 25), exp_disp}));
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [3:1] m);
    KEY[3:1] = ~m;
    tick();
    KEY[3:1] = 3'b111;
    tick();
  endtask

  initial begin
    KEY = 4'b1111;
    SW  = 10'b0;
    #5 KEY[0] = 1'b0;
    #1 chk_en = 1'b1;
    check("reset_low_ledr", 32'(LEDR), 32'd0);
    tick();
    tick();
    check("reset_held_ledr", 32'(LEDR), 32'd0);
    KEY[0] = 1'b1;
    tick();

    // One coin: 100p shows as 4.
    press(3'b100);
    check("coin_once_ledr", 32'(LEDR), 32'({5'd4, 5'b00000}));
    check("coin_once_model", 32'(exp_credit), 32'd100);

    // Chocolate: 100 - 80 = 20p.
    SW[4:0] = 5'b00010;
    press(3'b001);
    check("buy_choc_ledr", 32'(LEDR), 32'({5'd0, 5'b00010}));
    check("buy_choc_model", 32'(exp_credit), 32'd20);

    // Sandwich with only 20p: refused, display cleared.
    SW[4:0] = 5'b10000;
    press(3'b001);
    check("buy_short_ledr", 32'(LEDR), 32'd0);
    check("buy_short_model", 32'(exp_credit), 32'd20);

    // Two coins (220p) then sandwich: 20p left, item held.
    press(3'b100);
    press(3'b100);
    check("two_coins_ledr", 32'(LEDR), 32'({5'd8, 5'b00000}));
    press(3'b001);
    repeat (6) tick();
    check("sandwich_hold_ledr", 32'(LEDR), 32'({5'd0, 5'b10000}));

    // Held coin key counts once: 20 + 100 = 120p -> 4; item stays lit.
    KEY[3] = 1'b0;
    repeat (10) tick();
    KEY[3] = 1'b1;
    tick();
    check("coin_hold_ledr", 32'(LEDR), 32'({5'd4, 5'b10000}));

    // Refund beats insert.
    press(3'b110);
    check("refund_insert_ledr", 32'(LEDR), 32'd0);

    // Ceiling: seven coins reach 700p, the eighth would exceed 775p.
    repeat (8) press(3'b100);
    check("ceiling_ledr", 32'(LEDR), 32'({5'd28, 5'b00000}));
    check("ceiling_model", 32'(exp_credit), 32'd700);

    SW[4:0] = 5'b01000;
    press(3'b001);
    check("buy_item3_ledr", 32'(LEDR), 32'({5'd23, 5'b01000}));

    SW[4:0] = 5'b00011;
    press(3'b001);
    check("buy_multi_sel_ledr", 32'(LEDR), 32'({5'd23, 5'b00000}));

    SW = 10'b1110000000;
    press(3'b001);
    check("buy_no_sel_ledr", 32'(LEDR), 32'({5'd23, 5'b00000}));

    // Buy beats insert: 580 - 50 = 530p -> 21.
    SW = 10'b0000000001;
    press(3'b101);
    check("buy_insert_ledr", 32'(LEDR), 32'({5'd21, 5'b00001}));

    // Switches alone change nothing.
    SW[4:0] = 5'b10000;
    repeat (3) tick();
    check("sw_only_ledr", 32'(LEDR), 32'({5'd21, 5'b00001}));

    // Exact price: 200p buys the sandwich and leaves zero.
    press(3'b111);
    press(3'b100);
    press(3'b100);
    press(3'b001);
    check("exact_price_ledr", 32'(LEDR), 32'({5'd0, 5'b10000}));
    check("exact_price_model", 32'(exp_credit), 32'd0);

    // Asynchronous reset between clock edges.
    press(3'b100);
    check("pre_async_ledr", 32'(LEDR), 32'({5'd4, 5'b10000}));
    #3 KEY[0] = 1'b0;
    #1 check("async_reset_ledr", 32'(LEDR), 32'd0);
    tick();
    KEY[0] = 1'b1;
    tick();
    press(3'b100);
    check("after_reset_coin_ledr", 32'(LEDR), 32'({5'd4, 5'b00000}));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
